// File: rtl/sdm_demodulator_if.sv
// +------------------------------------------------------------------+
// | sdm_demodulator_if : bitstream-in / PCM-out bus     | rev 1.0    |
// +------------------------------------------------------------------+
`default_nettype none

interface sdm_demodulator_if;
  logic               valid_in;
  logic               sdm_in;
  logic               valid_out;
  logic signed [15:0] audio_out;

  modport master (
    output valid_in,
    output sdm_in,
    input  valid_out,
    input  audio_out
  );

  modport slave (
    input  valid_in,
    input  sdm_in,
    output valid_out,
    output audio_out
  );
endinterface

`default_nettype wire

// File: rtl/sdm_demodulator.sv
// +------------------------------------------------------------------+
// | sdm_demodulator : 3rd-order CIC, 1-bit SDM to 16-bit PCM | rev 1.0 |
// +------------------------------------------------------------------+
`default_nettype none

module sdm_demodulator #(
  parameter int DECIM_LOG2 = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  sdm_demodulator_if.slave bus
);

  localparam int ORDER = 3;
  localparam int ACC_W = ORDER * DECIM_LOG2 + 2;
  localparam int SHIFT = ORDER * DECIM_LOG2 - 15;

  localparam logic signed [ACC_W-1:0] C_SAT_MAX = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] C_SAT_MIN = ACC_W'(-32768);

  logic signed [ACC_W-1:0] r_i1, r_i2, r_i3;
  logic signed [ACC_W-1:0] r_d1, r_d2, r_d3;
  logic [DECIM_LOG2-1:0]   r_dcnt;
  logic                    r_valid_out;
  logic signed [15:0]      r_audio_out;

  logic signed [ACC_W-1:0] w_x;
  logic signed [ACC_W-1:0] w_i1, w_i2, w_i3;
  logic signed [ACC_W-1:0] w_c1, w_c2, w_c3;
  logic signed [ACC_W-1:0] w_s;
  logic signed [15:0]      w_sat;
  logic                    w_last;

  assign w_x    = bus.sdm_in ? ACC_W'(1) : {ACC_W{1'b1}};
  assign w_last = &r_dcnt;

  // Integrators wrap freely; the comb differences recover the exact result.
  assign w_i1 = r_i1 + w_x;
  assign w_i2 = r_i2 + w_i1;
  assign w_i3 = r_i3 + w_i2;

  assign w_c1 = w_i3 - r_d1;
  assign w_c2 = w_c1 - r_d2;
  assign w_c3 = w_c2 - r_d3;

  assign w_s = w_c3 >>> SHIFT;

  always_comb begin
    w_sat = w_s[15:0];
    if (w_s > C_SAT_MAX)
      w_sat = 16'sh7fff;
    else if (w_s < C_SAT_MIN)
      w_sat = 16'sh8000;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_i1        <= '0;
      r_i2        <= '0;
      r_i3        <= '0;
      r_d1        <= '0;
      r_d2        <= '0;
      r_d3        <= '0;
      r_dcnt      <= '0;
      r_valid_out <= 1'b0;
      r_audio_out <= '0;
    end else begin
      r_valid_out <= bus.valid_in & w_last;
      if (bus.valid_in) begin
        r_i1   <= w_i1;
        r_i2   <= w_i2;
        r_i3   <= w_i3;
        r_dcnt <= r_dcnt + 1'b1;
        if (w_last) begin
          r_d1        <= w_i3;
          r_d2        <= w_c1;
          r_d3        <= w_c2;
          r_audio_out <= w_sat;
        end
      end
    end
  end

  assign bus.valid_out = r_valid_out;
  assign bus.audio_out = r_audio_out;

endmodule

`default_nettype wire

// File: tb/tb_sdm_demodulator.sv
// +------------------------------------------------------------------+
// | tb_sdm_demodulator : random-stimulus bench vs CIC kernel model | rev 1.0 |
// +------------------------------------------------------------------+
`default_nettype none

module tb_sdm_demodulator;

  localparam int DECIM_LOG2 = 6;
  localparam int R          = 1 << DECIM_LOG2;
  localparam int SHIFT      = 3 * DECIM_LOG2 - 15;
  localparam int KLEN       = 3 * R - 2;

  logic clk;
  logic rst_n;

  sdm_demodulator_if bus ();

  sdm_demodulator #(.DECIM_LOG2(DECIM_LOG2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int     checks   = 0;
  int     failures = 0;
  int     h [KLEN];
  int     hist [$];
  int     acc_cnt;
  int     n_out;
  longint exp_audio;

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Output = boxcar^3 kernel applied to the +/-1 history, scaled and clipped.
  function automatic longint model_out();
    longint y = 0;
    longint s;
    int n = hist.size();
    for (int k = 0; k < KLEN; k++)
      if (n - 1 - k >= 0) y += longint'(h[k]) * longint'(hist[n - 1 - k]);
    s = y >>> SHIFT;
    if (s > 32767)  s = 32767;
    if (s < -32768) s = -32768;
    return s;
  endfunction

  function automatic logic pat_bit(input int mode, input int idx);
    case (mode)
      0:       return 1'b1;
      1:       return 1'b0;
      2:       return (idx % 2) == 0;
      3:       return (idx % 4) != 3;
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  task automatic step(input logic v, input logic b);
    logic exp_v;
    @(negedge clk);
    bus.valid_in = v;
    bus.sdm_in   = b;
    @(posedge clk);
    #1;
    exp_v = 1'b0;
    if (v) begin
      hist.push_back(b ? 1 : -1);
      acc_cnt++;
      if (acc_cnt % R == 0) begin
        exp_v = 1'b1;
        n_out++;
        exp_audio = model_out();
      end
    end
    check("valid_out", longint'(bus.valid_out), longint'(exp_v));
    if (n_out == 0)
      check("audio_idle", longint'(bus.audio_out), 0);
    else if (n_out >= 3)
      check(exp_v ? "audio_new" : "audio_hold", longint'(bus.audio_out), exp_audio);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    bus.valid_in = 1'($urandom_range(0, 1));
    bus.sdm_in   = 1'($urandom_range(0, 1));
    rst_n = 1'b0;
    #1;
    check("rst_async_valid", longint'(bus.valid_out), 0);
    check("rst_async_audio", longint'(bus.audio_out), 0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_hold_audio", longint'(bus.audio_out), 0);
    @(negedge clk);
    bus.valid_in = 1'b0;
    rst_n = 1'b1;
    hist.delete();
    acc_cnt   = 0;
    n_out     = 0;
    exp_audio = 0;
  endtask

  // Runs until the requested number of frames has been accepted.
  task automatic run(input int mode, input int frames, input bit stalls);
    int idx = 0;
    while (idx < frames * R) begin
      if (stalls && ($urandom_range(0, 1) == 0)) begin
        step(1'b0, 1'($urandom_range(0, 1)));
      end else begin
        step(1'b1, pat_bit(mode, idx));
        idx++;
      end
    end
  endtask

  initial begin
    for (int k = 0; k < KLEN; k++) h[k] = 0;
    for (int a = 0; a < R; a++)
      for (int b = 0; b < R; b++)
        for (int c = 0; c < R; c++)
          h[a + b + c]++;

    rst_n        = 1'b1;
    bus.valid_in = 1'b0;
    bus.sdm_in   = 1'b0;
    acc_cnt      = 0;
    n_out        = 0;
    exp_audio    = 0;

    do_reset();
    repeat (100) step(1'b0, 1'($urandom_range(0, 1)));

    run(0, 5, 1'b0);
    check("fs_pos", longint'(bus.audio_out), 32767);

    do_reset();
    run(1, 5, 1'b0);
    check("fs_neg", longint'(bus.audio_out), -32768);

    do_reset();
    run(2, 5, 1'b0);
    check("alt_zero", longint'(bus.audio_out), 0);

    do_reset();
    run(3, 5, 1'b0);
    check("dc_half", longint'(bus.audio_out), 16384);

    do_reset();
    run(2, 5, 1'b1);
    check("alt_zero_stall", longint'(bus.audio_out), 0);

    do_reset();
    run(3, 5, 1'b1);
    check("dc_half_stall", longint'(bus.audio_out), 16384);

    do_reset();
    run(0, 5, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1);
    do_reset();
    run(1, 4, 1'b0);
    check("post_rst_neg", longint'(bus.audio_out), -32768);
    check("post_rst_frames", longint'(n_out), 4);

    do_reset();
    run(4, 8, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sdm_demodulator.md
# sdm_demodulator

Converts a 1-bit sigma-delta bitstream back into 16-bit signed PCM audio using a third-order CIC decimation filter. It is the receive-side counterpart of the audio-to-SDM modulator path and sits between an SDM source (external modulator, loopback, or pin input) and the audio sink. One instance is used per channel.

## Interface

Parameters:
- DECIM_LOG2, 6, log2 of the decimation ratio R; legal range 5..8, so R = 32..256.

Derived, not overridable:
- ORDER = 3.
- ACC_W = 3*DECIM_LOG2 + 2.
- SHIFT = 3*DECIM_LOG2 - 15.

Ports (one clock; reset is asynchronous and active-low):
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- valid_in  input  1  qualifies sdm_in. One bitstream sample is accepted per high cycle.
- sdm_in  input  1  bitstream sample: 1 maps to +1, 0 maps to -1.
- valid_out  output  1  single-cycle pulse; audio_out holds a new sample.
- audio_out  output  16  signed PCM sample; holds its value between pulses.

## Operation

Datapath:
- All internal arithmetic is two's complement at ACC_W bits.
- The three integrator stages wrap modulo 2^ACC_W. Wrap-around is required for correct CIC behaviour and must not be saturated.

On each cycle with valid_in=1 (an "accepted sample"):
- x = +1 if sdm_in=1, else -1.
- i1 += x; i2 += i1 (new value); i3 += i2 (new value). All three update in the same cycle using a cascaded combinational chain.
- The decimation counter dcnt (DECIM_LOG2 bits) increments and wraps at R.

On the accepted sample where dcnt == R-1 (the R-th sample):
- Comb chain, computed from the updated i3:
  - c1 = i3 - d1
  - c2 = c1 - d2
  - c3 = c2 - d3
- Delay registers update: d1 <= i3, d2 <= c1, d3 <= c2.
- Scaling: s = c3 >>> SHIFT (arithmetic shift).
- Saturation: s > 32767 gives 32767; s < -32768 gives -32768.
- audio_out <= saturated s; valid_out <= 1 on the next cycle.

Cycles with valid_in=0:
- All state holds, including dcnt, integrators, delays and audio_out.
- Gaps of any length are allowed between accepted samples.

Gain and settling:
- DC gain is R^3 = 2^(3*DECIM_LOG2), so full scale maps to ±32768 before saturation.
- The first two outputs after reset are transient. From the 3rd output onward the output is the exact CIC response to the input.

Reset (rst_n=0, asynchronous, allowed at any time including mid-frame):
- Clears i1..i3, d1..d3, dcnt, audio_out=0 and valid_out=0 immediately.
- After rst_n deasserts, counting restarts from sample 0. A partial frame in progress is discarded.

## Timing

- valid_out is registered. It is high exactly one cycle, namely the cycle after the clock edge that accepts the R-th sample of a frame.
- audio_out changes on that same edge and is stable while valid_out=1 and afterward.
- With valid_in held at 1 continuously, valid_out pulses every R cycles.
- Latency: one clock from acceptance of the R-th sample to output.
- No backpressure. The downstream must accept each valid_out pulse.
- valid_out is never high for two consecutive cycles, because R ≥ 32.

## Test plan

All scenarios use DECIM_LOG2=6 (R=64, SHIFT=3) and "from the 3rd output onward" unless stated otherwise.

1. Reset check: assert rst_n=0 with arbitrary inputs. Require audio_out=0 and valid_out=0 asynchronously. Release reset, then drive valid_in=0 for 100 cycles: no valid_out pulse.
2. Positive full scale: sdm_in=1 with valid_in=1 continuously. Require pulses every 64 cycles, and audio_out=32767 (saturated from 32768).
3. Negative full scale: sdm_in=0 continuously. Require audio_out=-32768.
4. Midscale and fractional DC:
   - Alternating 1,0: require audio_out=0.
   - Repeating 1,1,1,0 (mean +0.5): require audio_out=16384.
5. Stalls: repeat scenario 4 with valid_in randomly low about 50% of the time. Require the identical audio_out sequence, and exactly one valid_out pulse per 64 accepted samples, each occurring 1 cycle after the 64th.
6. Reset mid-frame: after 5 outputs of all-ones, pulse rst_n low after 20 samples of the next frame, then switch to all-zeros. Require:
   - audio_out=0 during and after reset, until the first pulse.
   - The first post-reset pulse arrives after 64 fresh samples.
   - audio_out=-32768 from the 3rd post-reset output.
